sm_seq_multiplier: RTL and testbench

- Parametrised, multi-cycle sign-magnitude multiplier for the signed calculator datapath; successor to the fixed 3-bit combinational multiplier.
- Operand width is generic.
- Uses a valid/ready handshake on both input and output so it can sit between the operand registers and the result/display stage.
- Iterative shift-add on magnitudes.
- Result sign is the XOR of operand signs, with negative zero normalised to positive zero.

---
 rtl/sm_seq_multiplier_pkg.sv | 30 +++
 rtl/sm_seq_multiplier.sv | 144 ++++++++++++++
 tb/tb_sm_seq_multiplier.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm_seq_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the signed calculator datapath blocks.
//   - state_e         : control state of the sequential multiplier
//   - CALC_DEFAULT_W  : default operand width (sign + magnitude), shared with
//                       the combinational adder/multiplier blocks
//   - sm_sign/sm_mag  : field extraction for sign-magnitude operands of up to
//                       16 bits; the caller passes the true operand width
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam int CALC_DEFAULT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Sign bit of a w-bit sign-magnitude value held in the low bits of v.
    function automatic logic sm_sign(input logic [15:0] v, input int w);
        return v[w-1];
    endfunction

    // Magnitude field (low w-1 bits) of a w-bit sign-magnitude value.
    function automatic logic [15:0] sm_mag(input logic [15:0] v, input int w);
        return v & ((16'h0001 << (w - 1)) - 16'h0001);
    endfunction

endpackage

// File: rtl/sm_seq_multiplier.sv
// -----------------------------------------------------------------------------
// sm_seq_multiplier
// Multi-cycle sign-magnitude multiplier. The magnitudes are multiplied by
// iterative shift-add, one multiplier bit per cycle, for exactly MAG cycles
// (no early exit). The result sign is the XOR of the operand signs, forced to
// 0 when the magnitude product is zero.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   A, B       in   W-bit sign-magnitude operands (MSB = sign)
//   in_valid   in   operands valid
//   in_ready   out  operands can be accepted (IDLE only)
//   P          out  PW-bit sign-magnitude product, P[PW-1] = sign; registered,
//                   updated only when a result completes
//   out_valid  out  P valid (DONE)
//   out_ready  in   consumer takes P
//   busy       out  operation in flight (BUSY or DONE)
// -----------------------------------------------------------------------------
module sm_seq_multiplier
    import calc_pkg::*;
#(
    parameter int W = CALC_DEFAULT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      A,
    input  logic [W-1:0]      B,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [2*W-2:0]    P,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam int MAG = W - 1;
    localparam int PW  = 2 * W - 1;
    localparam int AW  = 2 * MAG;
    localparam int CW  = $clog2(MAG + 1);

    state_e          state_q, state_d;
    logic            sign_q, sign_d;
    logic [MAG-1:0]  mcand_q, mcand_d;
    logic [MAG-1:0]  mplr_q, mplr_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   p_q, p_d;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;
    logic [AW-1:0]   partial_s;

    // Next-state, datapath and result composition.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        // Shifted multiplicand contributed by the current multiplier bit.
        if (mplr_q[0]) begin
            partial_s = AW'(mcand_q) << cnt_q;
        end else begin
            partial_s = {AW{1'b0}};
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_d  = sm_sign(16'(A), W) ^ sm_sign(16'(B), W);
                    mcand_d = MAG'(sm_mag(16'(A), W));
                    mplr_d  = MAG'(sm_mag(16'(B), W));
                    acc_d   = {AW{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                acc_d  = acc_q + partial_s;
                mplr_d = mplr_q >> 1'b1;
                cnt_d  = cnt_q + CW'(1);
                // Last magnitude bit: publish the result on this same edge so
                // out_valid rises exactly MAG cycles after the accept edge.
                if (cnt_q == CW'(MAG - 1)) begin
                    p_d     = {sign_q & (acc_d != {AW{1'b0}}), acc_d};
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and decoded-output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sign_q      <= 1'b0;
            mcand_q     <= {MAG{1'b0}};
            mplr_q      <= {MAG{1'b0}};
            acc_q       <= {AW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            p_q         <= {PW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mcand_q     <= mcand_d;
            mplr_q      <= mplr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            // Handshake outputs are decoded from the next state so they are
            // flops that always agree with state_q.
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign P         = p_q;

endmodule

// File: tb/tb_sm_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_sm_seq_multiplier
// Self-checking bench for sm_seq_multiplier with a W=3 and a W=8 instance.
// Expected products come from signed integer arithmetic on the decoded
// operand values.
// -----------------------------------------------------------------------------
module tb_sm_seq_multiplier;

    logic        clk;
    logic        rst_n;

    logic [2:0]  a3, b3;
    logic        iv3, ir3, ov3, or3, busy3;
    logic [4:0]  p3;

    logic [7:0]  a8, b8;
    logic        iv8, ir8, ov8, or8, busy8;
    logic [14:0] p8;

    int vectors;
    int miscompares;

    sm_seq_multiplier #(.W(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a3),
        .B         (b3),
        .in_valid  (iv3),
        .in_ready  (ir3),
        .P         (p3),
        .out_valid (ov3),
        .out_ready (or3),
        .busy      (busy3)
    );

    sm_seq_multiplier #(.W(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a8),
        .B         (b8),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .P         (p8),
        .out_valid (ov8),
        .out_ready (or8),
        .busy      (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decode to signed integers, multiply, re-encode.
    function automatic logic [14:0] model(input bit w8, input logic [7:0] a, input logic [7:0] b);
        int mw, ma, mb, va, vb, prod, pm;
        logic [14:0] r;
        mw = w8 ? 7 : 2;
        ma = int'(a) % (1 << mw);
        mb = int'(b) % (1 << mw);
        va = a[mw] ? -ma : ma;
        vb = b[mw] ? -mb : mb;
        prod = va * vb;
        pm = (prod < 0) ? -prod : prod;
        if (w8) begin
            r = {(prod < 0), 14'(pm)};
        end else begin
            r = {10'd0, (prod < 0), 4'(pm)};
        end
        return r;
    endfunction

    function automatic logic [14:0] obs_p(input bit w8);
        return w8 ? p8 : {10'd0, p3};
    endfunction

    function automatic logic obs_valid(input bit w8);
        return w8 ? ov8 : ov3;
    endfunction

    function automatic logic obs_ready(input bit w8);
        return w8 ? ir8 : ir3;
    endfunction

    task automatic set_in(input bit w8, input logic [7:0] a, input logic [7:0] b, input logic v);
        if (w8) begin
            a8 = a; b8 = b; iv8 = v;
        end else begin
            a3 = a[2:0]; b3 = b[2:0]; iv3 = v;
        end
    endtask

    task automatic set_out_ready(input bit w8, input logic v);
        if (w8) or8 = v; else or3 = v;
    endtask

    // Idle gap, present operands for one edge, then scramble inputs and wait
    // (bounded) for out_valid. Result is left unconsumed.
    task automatic run_op(input bit w8, input logic [7:0] a, input logic [7:0] b, input int gap,
                          output logic [14:0] p_obs, output int lat);
        for (int g = 0; g < gap; g++) begin
            set_in(w8, 8'($urandom), 8'($urandom), 1'b0);
            @(posedge clk); #1;
        end
        set_in(w8, a, b, 1'b1);
        @(posedge clk); #1;
        set_in(w8, 8'($urandom), 8'($urandom), 1'($urandom));
        lat = 0;
        while (!obs_valid(w8) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            set_in(w8, 8'($urandom), 8'($urandom), 1'($urandom));
        end
        set_in(w8, 8'($urandom), 8'($urandom), 1'b0);
        p_obs = obs_p(w8);
    endtask

    task automatic consume(input bit w8);
        set_out_ready(w8, 1'b1);
        @(posedge clk); #1;
        set_out_ready(w8, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (ir3 !== 1'b1 || ov3 !== 1'b0 || busy3 !== 1'b0 || p3 !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_w3: ir=%b ov=%b busy=%b P=%b, want ir=1 ov=0 busy=0 P=00000", ir3, ov3, busy3, p3);
        end
        vectors++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0 || p8 !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_w8: ir=%b ov=%b busy=%b P=%h, want ir=1 ov=0 busy=0 P=0000", ir8, ov8, busy8, p8);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [2:0] ta [3];
        logic [2:0] tb [3];
        logic [4:0] tp [3];
        logic [14:0] p;
        int lat;
        ta[0] = 3'b011; tb[0] = 3'b111; tp[0] = 5'b11001;
        ta[1] = 3'b100; tb[1] = 3'b011; tp[1] = 5'b00000;
        ta[2] = 3'b101; tb[2] = 3'b101; tp[2] = 5'b00001;
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, {5'd0, ta[i]}, {5'd0, tb[i]}, 1, p, lat);
            vectors++;
            if (lat !== 2) begin
                miscompares++;
                $display("FAIL directed_latency[%0d]: got %0d cycles, want 2", i, lat);
            end
            vectors++;
            if (p[4:0] !== tp[i]) begin
                miscompares++;
                $display("FAIL directed_product[%0d]: A=%b B=%b P=%b, want %b", i, ta[i], tb[i], p[4:0], tp[i]);
            end
            consume(1'b0);
            vectors++;
            if (ov3 !== 1'b0 || ir3 !== 1'b1) begin
                miscompares++;
                $display("FAIL directed_release[%0d]: ov=%b ir=%b, want ov=0 ir=1", i, ov3, ir3);
            end
        end
    endtask

    task automatic test_sweep;
        logic [5:0] code;
        logic [14:0] p, exp;
        int lat;
        for (int i = 0; i < 64; i++) begin
            code = 6'(i);
            exp  = model(1'b0, {5'd0, code[5:3]}, {5'd0, code[2:0]});
            run_op(1'b0, {5'd0, code[5:3]}, {5'd0, code[2:0]}, int'($urandom_range(0, 3)), p, lat);
            vectors++;
            if (p !== exp || lat !== 2) begin
                miscompares++;
                $display("FAIL sweep A=%b B=%b: P=%b lat=%0d, want P=%b lat=2", code[5:3], code[2:0], p[4:0], lat, exp[4:0]);
            end
            consume(1'b0);
        end
    endtask

    task automatic test_w8;
        logic [7:0] a, b;
        logic [14:0] p, exp;
        int lat;
        run_op(1'b1, 8'h7F, 8'hFF, 0, p, lat);
        vectors++;
        if (p !== 15'h7F01 || lat !== 7) begin
            miscompares++;
            $display("FAIL w8_max: P=%h lat=%0d, want P=7f01 lat=7", p, lat);
        end
        consume(1'b1);
        run_op(1'b1, 8'h80, 8'h85, 1, p, lat);
        vectors++;
        if (p !== 15'h0000) begin
            miscompares++;
            $display("FAIL w8_negzero: P=%h, want 0000", p);
        end
        consume(1'b1);
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            exp = model(1'b1, a, b);
            run_op(1'b1, a, b, int'($urandom_range(0, 2)), p, lat);
            vectors++;
            if (p !== exp || lat !== 7) begin
                miscompares++;
                $display("FAIL w8_random A=%h B=%h: P=%h lat=%0d, want P=%h lat=7", a, b, p, lat, exp);
            end
            consume(1'b1);
        end
    endtask

    task automatic test_backpressure;
        logic [14:0] p;
        int lat;
        bit bad;
        run_op(1'b0, 8'h03, 8'h02, 0, p, lat);
        vectors++;
        if (p[4:0] !== 5'b00110) begin
            miscompares++;
            $display("FAIL bp_result: P=%b, want 00110", p[4:0]);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_in(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            @(posedge clk); #1;
            if (p3 !== 5'b00110 || ov3 !== 1'b1 || ir3 !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL bp_hold: P=%b ov=%b ir=%b, want P=00110 ov=1 ir=0 throughout", p3, ov3, ir3);
        end
        set_in(1'b0, 8'h00, 8'h00, 1'b0);
        consume(1'b0);
        vectors++;
        if (ir3 !== 1'b1 || ov3 !== 1'b0 || p3 !== 5'b00110) begin
            miscompares++;
            $display("FAIL bp_release: ir=%b ov=%b P=%b, want ir=1 ov=0 P=00110", ir3, ov3, p3);
        end
        run_op(1'b0, 8'h07, 8'h03, 0, p, lat);
        vectors++;
        if (p[4:0] !== 5'b11001 || lat !== 2) begin
            miscompares++;
            $display("FAIL bp_next: P=%b lat=%0d, want P=11001 lat=2", p[4:0], lat);
        end
        consume(1'b0);
    endtask

    task automatic test_reset_mid;
        logic [7:0] a, b;
        logic [14:0] p, exp;
        int lat;
        bit bad;
        set_in(1'b1, 8'h7F, 8'h7F, 1'b1);
        @(posedge clk); #1;
        set_in(1'b1, 8'h00, 8'h00, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        vectors++;
        if (busy8 !== 1'b1 || ov8 !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_busy: busy=%b ov=%b, want busy=1 ov=0", busy8, ov8);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0 || p8 !== 15'd0 || busy8 !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_clear: ir=%b ov=%b P=%h busy=%b, want ir=1 ov=0 P=0000 busy=0", ir8, ov8, p8, busy8);
        end
        #2;
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
            if (ov8 !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL rstmid_nopulse: out_valid asserted after reset abort, want 0");
        end
        a = 8'($urandom);
        b = 8'($urandom);
        exp = model(1'b1, a, b);
        run_op(1'b1, a, b, 0, p, lat);
        vectors++;
        if (p !== exp || lat !== 7) begin
            miscompares++;
            $display("FAIL rstmid_after A=%h B=%h: P=%h lat=%0d, want P=%h lat=7", a, b, p, lat, exp);
        end
        consume(1'b1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        a3 = 3'd0; b3 = 3'd0; iv3 = 1'b0; or3 = 1'b0;
        a8 = 8'd0; b8 = 8'd0; iv8 = 1'b0; or8 = 1'b0;
        test_reset;
        test_directed;
        test_sweep;
        test_w8;
        test_backpressure;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
